// File: rtl/sym_ser_pkg.sv
// Shared definitions for the symbol serializer: symbol width, FSM states and
// the length clamp used when a word is accepted.
package sym_ser_pkg;

  localparam int unsigned SYMW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2
  } state_t;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned nsym);
    return (len > nsym) ? nsym : len;
  endfunction

endpackage

// File: rtl/sym_shreg.sv
// Loadable left-shift register of NSYM symbols; the top symbol is always
// visible and zeros are shifted in from the bottom.
module sym_shreg
  import sym_ser_pkg::*;
#(
  parameter int unsigned NSYM = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [SYMW*NSYM-1:0]   data_i,
  output logic [SYMW-1:0]        top_o
);

  logic [SYMW*NSYM-1:0] sr_q;
  logic [SYMW*NSYM-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[SYMW*NSYM-SYMW-1:0], {SYMW{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign top_o = sr_q[SYMW*NSYM-1 -: SYMW];

endmodule

// File: rtl/sym_serializer.sv
// Upstream feeder: pulses a registered reset to the downstream FSM, then
// plays a word out one 2-bit symbol per clock, MS symbol first.
module sym_serializer
  import sym_ser_pkg::*;
#(
  parameter int unsigned NSYM = 16,
  parameter int unsigned LENW = 5
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   load,
  input  logic [SYMW*NSYM-1:0]   word,
  input  logic [LENW-1:0]        len,
  input  logic                   stall,
  output logic                   ready,
  output logic [SYMW-1:0]        a,
  output logic                   a_valid,
  output logic                   fsm_res,
  output logic                   done
);

  state_t               state_q;
  logic [LENW-1:0]      cnt_q;
  logic                 ready_q;
  logic [SYMW-1:0]      a_q;
  logic                 a_valid_q;
  logic                 fsm_res_q;
  logic                 done_q;

  logic [LENW-1:0]      eff_len;
  logic [SYMW*NSYM-1:0] load_data;
  logic                 sh_load;
  logic                 sh_shift;
  logic [SYMW-1:0]      sh_top;

  assign eff_len   = LENW'(clamp_len(32'(len), NSYM));
  assign load_data = word << (SYMW * (NSYM - 32'(eff_len)));

  // The register is popped into a_q one cycle ahead, so its top always holds
  // the symbol that follows the one currently on a.
  assign sh_load  = (state_q == IDLE) && load && (eff_len != '0);
  assign sh_shift = (state_q == PRIME) ||
                    ((state_q == SHIFT) && !stall && (cnt_q != LENW'(1)));

  sym_shreg #(
    .NSYM (NSYM)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (res),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (load_data),
    .top_o   (sh_top)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      fsm_res_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            if (eff_len != '0) begin
              state_q   <= PRIME;
              cnt_q     <= eff_len;
              ready_q   <= 1'b0;
              fsm_res_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        PRIME: begin
          state_q   <= SHIFT;
          fsm_res_q <= 1'b1;
          a_q       <= sh_top;
          a_valid_q <= 1'b1;
        end
        SHIFT: begin
          if (!stall) begin
            if (cnt_q == LENW'(1)) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              ready_q   <= 1'b1;
              a_q       <= '0;
              a_valid_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q - LENW'(1);
              a_q   <= sh_top;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          ready_q   <= 1'b1;
          a_q       <= '0;
          a_valid_q <= 1'b0;
          fsm_res_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign a       = a_q;
  assign a_valid = a_valid_q;
  assign fsm_res = fsm_res_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sym_serializer.sv
// Self-checking bench for sym_serializer: a scoreboard queue of expected
// symbols (-1 marks the done pulse) is consumed by a negedge monitor.
module tb_sym_serializer;

  localparam int NSYM = 16;
  localparam int LENW = 5;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        load = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] word = '0;
  logic [4:0]  len = '0;
  logic        ready;
  logic [1:0]  a;
  logic        a_valid;
  logic        fsm_res;
  logic        done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sym_serializer #(
    .NSYM (NSYM),
    .LENW (LENW)
  ) dut (
    .clk     (clk),
    .res     (res),
    .load    (load),
    .word    (word),
    .len     (len),
    .stall   (stall),
    .ready   (ready),
    .a       (a),
    .a_valid (a_valid),
    .fsm_res (fsm_res),
    .done    (done)
  );

  always @(negedge clk) begin
    logic [31:0] a_ext;
    a_ext = {30'b0, a};
    if (a_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0] < 0) begin
        errors++;
        $display("FAIL sym_unexpected got a=%0d expected %0s", a,
                 (exp_q.size() == 0) ? "nothing" : "done");
      end else begin
        if (a_ext !== exp_q[0]) begin
          errors++;
          $display("FAIL sym_value got a=%0d expected %0d", a, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0] >= 0) begin
        errors++;
        $display("FAIL done_unexpected got done=1 expected %0s",
                 (exp_q.size() == 0) ? "nothing" : "symbol");
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int l);
    int n;
    n = (l > NSYM) ? NSYM : l;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(int'(w[2*(n-1-k) +: 2]));
    end
    exp_q.push_back(-1);
  endtask

  task automatic test_reset();
    res = 1'b0; load = 1'b1; word = 32'h1234_5678; len = 5'd5;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({ready, a, a_valid, fsm_res, done} !== 6'b1_00_0_1_0) begin
        errors++;
        $display("FAIL reset_outputs got %b expected 100010", {ready, a, a_valid, fsm_res, done});
      end
    end
    @(posedge clk); #1;
    load = 1'b0; res = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || a_valid !== 1'b0 || fsm_res !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle got r=%b v=%b f=%b expected 1 0 1", ready, a_valid, fsm_res);
    end
  endtask

  task automatic test_regnum();
    int n;
    bit got_done;
    @(posedge clk); #1;
    word = 32'd73995; len = 5'd9; load = 1'b1;
    push_word(32'd73995, 9);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, a, a_valid, fsm_res} !== 5'b0_00_0_0) begin
      errors++;
      $display("FAIL regnum_prime got %b expected 00000", {ready, a, a_valid, fsm_res});
    end
    n = 0; got_done = 0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got_done = 1;
      else begin
        checks++;
        if (a_valid !== 1'b1 || fsm_res !== 1'b1) begin
          errors++;
          $display("FAIL regnum_valid cycle %0d got v=%b f=%b expected 1 1", n, a_valid, fsm_res);
        end
      end
    end
    checks++;
    if (!got_done || n != 10) begin
      errors++;
      $display("FAIL regnum_latency got %0d cycles (done=%0d) expected 10", n, got_done);
    end
    checks++;
    if (ready !== 1'b1 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL regnum_done_idle got r=%b v=%b expected 1 0", ready, a_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL regnum_done_width got done=%b expected 0", done);
    end
  endtask

  task automatic test_stall();
    int n;
    bit got_done;
    @(posedge clk); #1;
    word = 32'd73995; len = 5'd9; load = 1'b1;
    push_word(32'd73995, 9);
    exp_q.insert(3, 0);
    exp_q.insert(3, 0);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    n = 0; got_done = 0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 4) begin
        checks++;
        if (a !== 2'd0) begin
          errors++;
          $display("FAIL stall_sym3 got a=%0d expected 0", a);
        end
        stall = 1'b1;
      end
      if (n == 6) stall = 1'b0;
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done || n != 12) begin
      errors++;
      $display("FAIL stall_latency got %0d cycles (done=%0d) expected 12", n, got_done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit got_done;
    @(posedge clk); #1;
    word = 32'd73995; len = 5'd9; load = 1'b1;
    push_word(32'd73995, 9);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    n = 0; got_done = 0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) begin load = 1'b1; word = 32'hFFFF_FFFF; len = 5'd16; end
      if (n == 4) load = 1'b0;
      if (done === 1'b1) begin
        got_done = 1;
        word = 32'b11_10_01; len = 5'd3; load = 1'b1;
        push_word(32'b11_10_01, 3);
      end else begin
        checks++;
        if (fsm_res !== 1'b1 || a_valid !== 1'b1) begin
          errors++;
          $display("FAIL ignored_load cycle %0d got f=%b v=%b expected 1 1", n, fsm_res, a_valid);
        end
      end
    end
    checks++;
    if (!got_done || n != 10) begin
      errors++;
      $display("FAIL ignored_load_latency got %0d cycles expected 10", n);
    end
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_res !== 1'b0 || ready !== 1'b0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_prime got f=%b r=%b v=%b expected 0 0 0", fsm_res, ready, a_valid);
    end
    n = 0; got_done = 0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done || n != 4) begin
      errors++;
      $display("FAIL b2b_latency got %0d cycles expected 4", n);
    end
  endtask

  task automatic test_len_bounds();
    int n;
    bit got_done;
    @(posedge clk); #1;
    word = 32'h0000_ABCD; len = 5'd0; load = 1'b1;
    exp_q.push_back(-1);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ready !== 1'b1 || fsm_res !== 1'b1 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL len0_done got d=%b r=%b f=%b v=%b expected 1 1 1 0", done, ready, fsm_res, a_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || a_valid !== 1'b0 || fsm_res !== 1'b1) begin
      errors++;
      $display("FAIL len0_after got d=%b v=%b f=%b expected 0 0 1", done, a_valid, fsm_res);
    end
    @(posedge clk); #1;
    word = 32'hFFFF_0000; len = 5'd20; load = 1'b1;
    push_word(32'hFFFF_0000, 20);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    n = 0; got_done = 0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done || n != 17) begin
      errors++;
      $display("FAIL clamp_latency got %0d cycles expected 17", n);
    end
  endtask

  task automatic test_reset_mid_word();
    int n;
    bit got_done;
    @(posedge clk); #1;
    word = 32'd73995; len = 5'd9; load = 1'b1;
    push_word(32'd73995, 9);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    res = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({ready, a, a_valid, fsm_res, done} !== 6'b1_00_0_1_0) begin
      errors++;
      $display("FAIL abort_idle got %b expected 100010", {ready, a, a_valid, fsm_res, done});
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || a_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done got d=%b v=%b expected 0 0", done, a_valid);
      end
    end
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    word = 32'd73995; len = 5'd9; load = 1'b1;
    push_word(32'd73995, 9);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    n = 0; got_done = 0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done || n != 10) begin
      errors++;
      $display("FAIL replay_latency got %0d cycles expected 10", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_regnum();
    test_stall();
    test_back_to_back();
    test_len_bounds();
    test_reset_mid_word();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_serializer.md
Name: sym_serializer

Overview:
Upstream feeder for the 2-bit-input state machine (input `a`, 3-bit state-code output).
- Accepts a word of up to NSYM 2-bit symbols and a symbol count.
- Pulses a registered active-low reset to the downstream FSM, then presents one symbol per clock on `a`, most-significant symbol first.
- Replaces hand-written testbench stimulus, e.g. a registration number in binary, with a load/ready handshake.

Parameters:
- NSYM, 16, maximum symbols per word; word width is 2*NSYM.
- LENW, 5, width of `len`; must hold the value NSYM.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res  in  1  asynchronous active-low reset.
- load  in  1  request to start a word; accepted only when ready=1.
- word  in  2*NSYM  symbol source; the active symbols are word[2*L-1:0], where L is the effective length.
- len  in  LENW  requested symbol count; the effective length L is min(len, NSYM).
- stall  in  1  freezes the current symbol (no advance) while in SHIFT.
- ready  out  1  high in IDLE; load is accepted at an edge where ready=1 and load=1.
- a  out  2  current symbol to the downstream FSM.
- a_valid  out  1  high while `a` carries a word symbol.
- fsm_res  out  1  registered active-low reset for the downstream FSM.
- done  out  1  one-cycle pulse after the last symbol.

Behaviour:
- Async reset (res=0) forces IDLE immediately, with:
  - ready=1, a=0, a_valid=0, fsm_res=1, done=0;
  - index counter=0 and shift register=0.
- All outputs are registered. fsm_res comes straight from a flop so it never glitches.
- States: IDLE, PRIME, SHIFT.
- IDLE:
  - outputs ready=1, a=0, a_valid=0, fsm_res=1.
  - On an edge with load=1 and L>0: capture word[2*L-1:0] left-aligned into the shift register, set count=L, go to PRIME.
  - On an edge with load=1 and L=0: stay in IDLE and assert done=1 for the next cycle. No PRIME, no symbols.
- PRIME (exactly one cycle):
  - outputs fsm_res=0, a=0, a_valid=0, ready=0.
  - stall is ignored.
  - Next state: SHIFT.
- SHIFT:
  - outputs a = top symbol of the shift register, a_valid=1, fsm_res=1, ready=0.
  - At each edge with stall=0: shift left by 2 and decrement count.
  - When the symbol being left is the last one (count=1), go to IDLE and set done=1 for one cycle.
  - At each edge with stall=1: hold everything, so the same symbol repeats and a_valid stays 1.
- Latency: with no stalls, load accepted at edge E0 gives:
  - PRIME after E0;
  - symbol k presented after edge E(k+1);
  - IDLE with done=1 after edge E(L+1).
- done is high only in the first IDLE cycle after a word completes. ready is also 1 in that cycle, so a load in that cycle (back-to-back) is accepted and the next cycle is PRIME.
- A load while ready=0 is ignored; it is neither queued nor flagged.
- len>NSYM is clamped to NSYM; all 2*NSYM word bits are used.
- Reset mid-PRIME or mid-SHIFT aborts the word immediately with no done pulse. fsm_res returns to 1; the downstream FSM has its own reset tie-in.
- Stall also repeats the symbol into the downstream FSM, which has no enable. This is the intended stimulus behaviour.

Decomposition:
- Shared package sym_ser_pkg holds:
  - state encoding constants IDLE=2'd0, PRIME=2'd1, SHIFT=2'd2;
  - the symbol width constant SYMW=2.
- One natural sub-module, sym_shreg: loadable left-shift register of 2*NSYM bits.
  - inputs: load, shift-enable, load data (already left-aligned by the parent).
  - outputs: top SYMW bits.
  - The parent FSM owns the count and the handshake.

Test Plan:
1. Reset: res=0 for 2 cycles with load=1 -> ready=1, a=0, a_valid=0, fsm_res=1, done=0 throughout; nothing accepted.
2. Registration-number load: word=73995, len=9, one-cycle load -> one PRIME cycle with fsm_res=0, then a = 1,0,2,0,1,0,0,2,3 on 9 consecutive cycles with a_valid=1, then done=1 for one cycle and ready=1.
3. Stall: same word, stall=1 for 2 edges while a=0 at symbol index 3 -> a=0 held 3 cycles, the remaining order is unchanged, done is delayed by exactly 2 cycles.
4. Handshake: load pulsed during SHIFT -> ignored, word completes unchanged. Then load word=6'b11_10_01 with len=3 in the done cycle -> PRIME next cycle, then a=3,2,1.
5. Length bounds:
   - len=0 -> done pulse the next cycle with no PRIME and a_valid never high.
   - word=32'hFFFF_0000, len=20 -> clamped to 16: a=3 for 8 cycles, then a=0 for 8 cycles, then done.
6. Reset mid-word: res=0 after the 4th symbol of test 2 -> immediately IDLE values, no done pulse. A fresh load after res=1 replays the full sequence from symbol 0.
